// File: rtl/framebuffer_scanout.sv
// Scans a half-resolution framebuffer out as VGA. Each framebuffer pixel is shown as a 2x2 block.
// Reads, RGB, syncs and blanking share one two-stage pipeline, so all of them change on the same edge.
module framebuffer_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FB_WIDTH    = 320,
    parameter int CLK_DIV     = 4,
    parameter int ADDR_WIDTH  = 17,
    parameter int PIXEL_WIDTH = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [ADDR_WIDTH-1:0]  o_fb_addr,
    output logic                   o_fb_re,
    input  logic [PIXEL_WIDTH-1:0] i_fb_pixel,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic [3:0]             o_red,
    output logic [3:0]             o_green,
    output logic [3:0]             o_blue,
    output logic                   o_vblank,
    output logic                   o_frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]         DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]         DIV_PRE   = DW'(CLK_DIV - 2);
    localparam logic [HW-1:0]         H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]         H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0]         HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]         HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]         V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]         V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0]         VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]         VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_WIDTH-1:0] FB_STRIDE = ADDR_WIDTH'(FB_WIDTH);

    logic [DW-1:0]         r_div;
    logic [HW-1:0]         r_h;
    logic [VW-1:0]         r_v;
    logic [ADDR_WIDTH-1:0] r_row_base;

    logic r_tick_d;
    logic r_act_d;
    logic r_hs_d;
    logic r_vs_d;
    logic r_vb_d;
    logic r_fs_d;

    logic                  w_tick;
    logic                  w_pre_tick;
    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_v_act;
    logic                  w_active;
    logic                  w_hs_n;
    logic                  w_vs_n;
    logic                  w_vblank;
    logic                  w_first;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_pre_tick = (r_div == DIV_PRE);
    assign w_h_last   = (r_h == H_LAST);
    assign w_v_last   = (r_v == V_LAST);
    assign w_v_act    = (r_v < V_ACT);
    assign w_active   = (r_h < H_ACT) && w_v_act;
    assign w_hs_n     = !((r_h >= HS_START) && (r_h < HS_END));
    assign w_vs_n     = !((r_v >= VS_START) && (r_v < VS_END));
    assign w_vblank   = !w_v_act;
    assign w_first    = (r_h == '0) && (r_v == '0);
    // Horizontal doubling drops the LSB of h; vertical doubling advances the row only after odd lines.
    assign w_addr     = r_row_base + ADDR_WIDTH'(r_h[HW-1:1]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div      <= '0;
            r_h        <= '0;
            r_v        <= '0;
            r_row_base <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (w_h_last) begin
                r_h <= '0;
                if (w_v_last) begin
                    r_v        <= '0;
                    r_row_base <= '0;
                end else begin
                    r_v <= r_v + VW'(1);
                    if (r_v[0] && w_v_act) begin
                        r_row_base <= r_row_base + FB_STRIDE;
                    end
                end
            end else begin
                r_h <= r_h + HW'(1);
            end
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // The read is registered one cycle early, so the strobe lines up with the tick cycle itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fb_re   <= 1'b0;
            o_fb_addr <= '0;
        end else begin
            o_fb_re <= w_pre_tick && w_active;
            if (w_pre_tick && w_active) begin
                o_fb_addr <= w_addr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_d <= 1'b0;
            r_act_d  <= 1'b0;
            r_hs_d   <= 1'b1;
            r_vs_d   <= 1'b1;
            r_vb_d   <= 1'b0;
            r_fs_d   <= 1'b0;
        end else begin
            r_tick_d <= w_tick;
            r_fs_d   <= w_tick && w_first;
            if (w_tick) begin
                r_act_d <= w_active;
                r_hs_d  <= w_hs_n;
                r_vs_d  <= w_vs_n;
                r_vb_d  <= w_vblank;
            end
        end
    end

    // Read data is only looked at in the cycle after a tick, so stray bus values never reach RGB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_vblank      <= 1'b0;
            o_frame_start <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
        end else begin
            o_frame_start <= r_fs_d;
            if (r_tick_d) begin
                o_hsync  <= r_hs_d;
                o_vsync  <= r_vs_d;
                o_vblank <= r_vb_d;
                if (r_act_d) begin
                    o_red   <= i_fb_pixel[11:8];
                    o_green <= i_fb_pixel[7:4];
                    o_blue  <= i_fb_pixel[3:0];
                end else begin
                    o_red   <= '0;
                    o_green <= '0;
                    o_blue  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench: a full-size instance covers the real line timing, and a shrunken instance covers frame wrap, blanking and mid-line reset.
// A reference model queues the expected reads and pixels; a separate negedge monitor pops each entry and compares it with the DUT.
module tb_framebuffer_scanout;
    localparam int NI = 2;
    localparam int CD = 4;

    typedef struct packed { int due; logic [16:0] addr; } rd_t;
    typedef struct packed { int due; logic [15:0] v; } out_t;

    logic             clk = 1'b0;
    logic [1:0]       rst = 2'b11;
    logic [1:0]       re, hs, vs, vb, fs;
    logic [1:0][16:0] fb_addr;
    logic [1:0][11:0] pix = '0;
    logic [1:0][3:0]  red, green, blue;

    // Instance 0 uses the real geometry; instance 1 uses a shrunken geometry so whole frames fit.
    int g_ha[NI]  = '{640, 16};
    int g_hfp[NI] = '{16, 2};
    int g_hs[NI]  = '{96, 4};
    int g_ht[NI]  = '{800, 24};
    int g_va[NI]  = '{480, 8};
    int g_vfp[NI] = '{10, 1};
    int g_vs[NI]  = '{2, 2};
    int g_vt[NI]  = '{525, 12};
    int g_fbw[NI] = '{320, 8};

    int e_hper[NI]  = '{3200, 96};
    int e_hlow[NI]  = '{384, 16};
    int e_vlow[NI]  = '{6400, 192};
    int e_frame[NI] = '{1680000, 1152};

    rd_t  rdq[NI][$];
    out_t outq[NI][$];
    out_t cur[NI];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int mode[NI] = '{1, 0};
    bit started[NI] = '{0, 0};
    int mdv[NI], mh[NI], mv[NI];

    bit p_re[NI];
    logic [16:0] p_addr[NI];
    int p_mode[NI];

    bit hs_p[NI] = '{1, 1};
    bit vs_p[NI] = '{1, 1};
    int t_hfall[NI] = '{-1, -1};
    int t_hlow[NI]  = '{-1, -1};
    int t_vlow[NI]  = '{-1, -1};
    int t_fs[NI]    = '{-1, -1};
    bit found;

    always #5 clk = ~clk;

    framebuffer_scanout u_full (
        .i_clk(clk), .i_rst(rst[0]), .o_fb_addr(fb_addr[0]), .o_fb_re(re[0]),
        .i_fb_pixel(pix[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_red(red[0]),
        .o_green(green[0]), .o_blue(blue[0]), .o_vblank(vb[0]), .o_frame_start(fs[0])
    );

    framebuffer_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .FB_WIDTH(8)
    ) u_small (
        .i_clk(clk), .i_rst(rst[1]), .o_fb_addr(fb_addr[1]), .o_fb_re(re[1]),
        .i_fb_pixel(pix[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_red(red[1]),
        .o_green(green[1]), .o_blue(blue[1]), .o_vblank(vb[1]), .o_frame_start(fs[1])
    );

    function automatic logic [11:0] pixval(input int m, input logic [16:0] a);
        case (m)
            1:       return 12'hABC;
            2:       return 12'hFFF;
            default: return a[11:0];
        endcase
    endfunction

    function automatic logic [11:0] junk(input int m);
        return (m == 2) ? 12'hFFF : 12'h5A5;
    endfunction

    task automatic check(input string nm, input int k, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic model_step(input int k, input logic r);
        int a;
        logic act;
        out_t o;
        rd_t e;
        if (r) begin
            mdv[k] = 0; mh[k] = 0; mv[k] = 0;
            rdq[k].delete();
            outq[k].delete();
            started[k] = 1'b1;
            o.due = cyc;
            o.v = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
            outq[k].push_back(o);
            return;
        end
        if (!started[k]) return;
        if (mdv[k] == CD - 1) begin
            mdv[k] = 0;
            if (mh[k] == g_ht[k] - 1) begin
                mh[k] = 0;
                mv[k] = (mv[k] == g_vt[k] - 1) ? 0 : mv[k] + 1;
            end else begin
                mh[k]++;
            end
        end else begin
            mdv[k]++;
        end
        if (mdv[k] == CD - 1) begin
            act = (mh[k] < g_ha[k]) && (mv[k] < g_va[k]);
            a = (mv[k] / 2) * g_fbw[k] + mh[k] / 2;
            if (act) begin
                e.due = cyc;
                e.addr = 17'(a);
                rdq[k].push_back(e);
            end
            o.due = cyc + 2;
            o.v = {act ? pixval(mode[k], 17'(a)) : 12'h000,
                   !(mh[k] >= g_ha[k] + g_hfp[k] && mh[k] < g_ha[k] + g_hfp[k] + g_hs[k]),
                   !(mv[k] >= g_va[k] + g_vfp[k] && mv[k] < g_va[k] + g_vfp[k] + g_vs[k]),
                   mv[k] >= g_va[k],
                   (mh[k] == 0 && mv[k] == 0)};
            outq[k].push_back(o);
        end
    endtask

    // Reference model: runs just after each edge and describes the cycle that edge begins.
    initial begin
        logic [1:0] rs;
        forever begin
            @(posedge clk);
            cyc++;
            rs = rst;
            #2;
            for (int k = 0; k < NI; k++) model_step(k, rs[k]);
        end
    end

    // Framebuffer model: data appears in the cycle after a read and is junk in every other cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                p_re[k] = re[k];
                p_addr[k] = fb_addr[k];
                p_mode[k] = mode[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++)
                pix[k] = p_re[k] ? pixval(p_mode[k], p_addr[k]) : junk(p_mode[k]);
        end
    end

    // Monitor: pops expected reads and pixel outputs and compares them each cycle.
    initial begin
        rd_t e;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (started[k]) begin
                    while (rdq[k].size() > 0 && rdq[k][0].due < cyc) begin
                        e = rdq[k].pop_front();
                        check("fb_read_missing", k, re[k], 1);
                    end
                    if (re[k]) begin
                        if (rdq[k].size() == 0) begin
                            check("fb_read_unexpected", k, re[k], 0);
                        end else begin
                            e = rdq[k].pop_front();
                            check("fb_read_cycle", k, cyc, e.due);
                            check("fb_read_addr", k, fb_addr[k], e.addr);
                        end
                    end
                    while (outq[k].size() > 0 && outq[k][0].due <= cyc) cur[k] = outq[k].pop_front();
                    got = {red[k], green[k], blue[k], hs[k], vs[k], vb[k], fs[k]};
                    check("pixel_out", k, got, cur[k].v);
                    cur[k].v[0] = 1'b0;
                end
            end
        end
    end

    // Sync pulse widths, line period and frame period measured from the output edges.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst[k] === 1'b1) begin
                    t_hfall[k] = -1; t_hlow[k] = -1; t_vlow[k] = -1; t_fs[k] = -1;
                    hs_p[k] = 1'b1; vs_p[k] = 1'b1;
                end else if (started[k]) begin
                    if (hs_p[k] && hs[k] === 1'b0) begin
                        if (t_hfall[k] >= 0) check("hsync_period", k, cyc - t_hfall[k], e_hper[k]);
                        t_hfall[k] = cyc;
                        t_hlow[k] = cyc;
                    end
                    if (!hs_p[k] && hs[k] === 1'b1 && t_hlow[k] >= 0) begin
                        check("hsync_low", k, cyc - t_hlow[k], e_hlow[k]);
                        t_hlow[k] = -1;
                    end
                    if (vs_p[k] && vs[k] === 1'b0) t_vlow[k] = cyc;
                    if (!vs_p[k] && vs[k] === 1'b1 && t_vlow[k] >= 0) begin
                        check("vsync_low", k, cyc - t_vlow[k], e_vlow[k]);
                        t_vlow[k] = -1;
                    end
                    if (fs[k] === 1'b1) begin
                        if (t_fs[k] >= 0) check("frame_period", k, cyc - t_fs[k], e_frame[k]);
                        t_fs[k] = cyc;
                    end
                    hs_p[k] = (hs[k] === 1'b1);
                    vs_p[k] = (vs[k] === 1'b1);
                end
            end
        end
    end

    initial begin
        step(2);
        rst = 2'b00;
        step(1160);
        mode[1] = 2;
        step(1152);
        mode[1] = 0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (mh[1] == 10 && mv[1] == 5) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check("reset_point_reached", 1, found, 1);
        rst[1] = 1'b1;
        step(1);
        rst[1] = 1'b0;
        while (cyc < 3300) step(1);
        mode[0] = 0;
        while (cyc < 11400) step(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Display-side reader of the 320x240 12-bit framebuffer that the rasterizer writes. Generates 640x480@60 VGA timing from the single system clock using a pixel-tick divider. Each framebuffer pixel is shown as a 2x2 block. Reads the framebuffer read port (1-cycle latency) and drives registered RGB444 plus syncs, all aligned to the same pixel.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
FB_WIDTH, 320, framebuffer row stride
CLK_DIV, 4, system clocks per pixel tick (100 MHz -> 25 MHz)
ADDR_WIDTH, 17, framebuffer address width
PIXEL_WIDTH, 12, framebuffer pixel width (RGB444)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
o_fb_addr  out  ADDR_WIDTH  framebuffer read address
o_fb_re  out  1  framebuffer read enable, one-cycle pulse
i_fb_pixel  in  PIXEL_WIDTH  read data, valid the cycle after o_fb_re
o_hsync  out  1  horizontal sync, active low
o_vsync  out  1  vertical sync, active low
o_red  out  4  red, i_fb_pixel[11:8]
o_green  out  4  green, i_fb_pixel[7:4]
o_blue  out  4  blue, i_fb_pixel[3:0]
o_vblank  out  1  high while the output line is >= V_ACTIVE
o_frame_start  out  1  one-cycle pulse when pixel (0,0) is presented

Behaviour:
- Reset: div=0, h=0, v=0, row_base=0, o_fb_addr=0, o_fb_re=0, o_hsync=1, o_vsync=1, RGB=0, o_vblank=0, o_frame_start=0. Reset mid-frame restarts at (0,0) on the next cycle. No partial outputs.
- Divider counts 0..CLK_DIV-1. The tick cycle is div==CLK_DIV-1. Counters h (0..799) and v (0..524) advance only on tick.
- Wrap: h==799 on tick -> h=0, v++. v==524 with h==799 -> v=0, row_base=0.
- Addressing uses no multiplier. row_base += FB_WIDTH when h wraps and v[0]==1 and v<V_ACTIVE. o_fb_addr = row_base + (h>>1). Valid range is 0..76799. The last address, 76799, is at (639,479).
- Stage 0 (tick cycle T): if h<H_ACTIVE and v<H_ACTIVE rows (v<V_ACTIVE), assert o_fb_re for exactly one cycle with the address for (h,v). Otherwise o_fb_re=0 and the address holds.
- Stage 1 (T+1): i_fb_pixel is valid. Register RGB from i_fb_pixel if the delayed active flag is set, else 0.
- Sync and blanking are computed at T and delayed by a 2-cycle pipeline so they change on the same edge as RGB. All outputs for pixel (h,v) first appear at T+2 and hold for CLK_DIV cycles.
- o_hsync is low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751). o_vsync is low when 490 <= v < 492.
- RGB is forced to 0 in blanking regardless of i_fb_pixel.
- o_frame_start is high for one cycle at T+2 of the tick for (0,0).
- i_fb_pixel is ignored in any cycle not following o_fb_re.

Test Plan:
- Reset, run 2 frames -> hsync falling edges every 3200 cycles; low for 384 cycles. vsync low for 6400 cycles. Frame period is 1,680,000 cycles. o_frame_start pulses exactly once per frame.
- Monitor o_fb_re on line 0 -> 640 pulses with addresses 0,0,1,1,...,319,319. Line 1 repeats 0..319. Line 2 starts at 320. The last read of the frame is 76799. There are no reads on lines 480..524 or at h>=640.
- Return i_fb_pixel=12'hABC the cycle after each o_fb_re -> o_red=4'hA, o_green=4'hB, o_blue=4'hC exactly 2 cycles after the read pulse. RGB changes on the same edge as the sync transitions at the line boundary.
- Hold i_fb_pixel=12'hFFF constantly -> RGB=0 for all h>=640 and for v>=480. o_vblank=1 exactly during lines 480..524.
- Assert i_rst for 1 cycle mid-line (h=300, v=200) -> next cycle all outputs are at reset values. The following reads restart at address 0 and hsync timing restarts from h=0.
- Model the framebuffer as addr[11:0] -> each output pixel at (x,y) equals (((y>>1)*320+(x>>1)) & 12'hFFF) over a full frame.
